// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter for the core writeback (A) and a long-latency unit (B).
// A per-register scoreboard of pending long-op destinations flags read hazards and holds back WAW writes.
module regfile_write_arbiter #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_addr,
  output logic          iss_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          hazard1,
  output logic          hazard2,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW:0]   busy_cnt
);

  logic [NREG-1:0] r_busy;
  logic            r_rr_last_b;
  logic [AW:0]     r_busy_cnt;

  logic            w_a_elig;
  logic            w_b_elig;
  logic            w_contend;
  logic            w_grant_a;
  logic            w_grant_b;
  logic            w_iss_ready;
  logic            w_set;
  logic            w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic [AW:0]     w_cnt_nxt;

  // A must not overtake an outstanding long-op write to the same register.
  assign w_a_elig  = rst_n && a_valid && !r_busy[a_addr];
  assign w_b_elig  = rst_n && b_valid;
  assign w_contend = w_a_elig && w_b_elig;

  assign w_grant_a = w_a_elig && (!w_b_elig || r_rr_last_b);
  assign w_grant_b = w_b_elig && (!w_a_elig || !r_rr_last_b);

  // A reservation may reuse a register that B is retiring in the same cycle.
  assign w_iss_ready = rst_n && (!r_busy[iss_addr] || (w_grant_b && (b_addr == iss_addr)));

  assign w_set = iss_valid && w_iss_ready && (iss_addr != '0);
  assign w_clr = w_grant_b && r_busy[b_addr];

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[b_addr] = 1'b0;
    if (w_set) w_busy_nxt[iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  assign w_cnt_nxt = r_busy_cnt + {{AW{1'b0}}, w_set} - {{AW{1'b0}}, w_clr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_rr_last_b <= 1'b1;
      r_busy_cnt  <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      if (w_contend) r_rr_last_b <= w_grant_b;
    end
  end

  // Zero-latency write port; register 0 handshakes but is never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_grant_a && (a_addr != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = a_addr;
      rf_wdata = a_data;
    end else if (w_grant_b && (b_addr != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = b_addr;
      rf_wdata = b_data;
    end
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign iss_ready = w_iss_ready;
  assign hazard1   = rst_n && (rd_addr1 != '0) && r_busy[rd_addr1];
  assign hazard2   = rst_n && (rd_addr2 != '0) && r_busy[rd_addr2];
  assign busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: expected outputs are queued with each
// driven cycle and compared against the sampled outputs on the following negedge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0, iss_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, iss_ready, hazard1, hazard2, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst_n;
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        bv; logic [4:0] ba; logic [31:0] bd;
    logic        iv; logic [4:0] ia;
    logic [4:0]  r1; logic [4:0] r2;
  } stim_t;

  typedef struct packed {
    logic        we; logic ar; logic br; logic ir; logic h1; logic h2;
    logic [5:0]  cnt; logic [4:0] waddr; logic [31:0] wdata;
  } obs_t;

  obs_t exp_q[$];

  regfile_write_arbiter #(.DW(32), .AW(5), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                               logic bv, logic [4:0] ba, logic [31:0] bd,
                               logic iv, logic [4:0] ia, logic [4:0] r1, logic [4:0] r2);
    st = '{r, av, aa, ad, bv, ba, bd, iv, ia, r1, r2};
  endfunction

  function automatic obs_t mk(logic we, logic ar, logic br, logic ir, logic h1, logic h2,
                              logic [5:0] cnt, logic [4:0] wa, logic [31:0] wd);
    mk = '{we, ar, br, ir, h1, h2, cnt, wa, wd};
  endfunction

  function automatic obs_t sample();
    sample = '{rf_we, a_ready, b_ready, iss_ready, hazard1, hazard2, busy_cnt, rf_waddr, rf_wdata};
  endfunction

  task automatic apply(input stim_t s, input obs_t e);
    @(posedge clk);
    #1;
    rst_n = s.rst_n;
    a_valid = s.av; a_addr = s.aa; a_data = s.ad;
    b_valid = s.bv; b_addr = s.ba; b_data = s.bd;
    iss_valid = s.iv; iss_addr = s.ia;
    rd_addr1 = s.r1; rd_addr2 = s.r2;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    stim_t s[3];
    obs_t  e[3];
    obs_t  got, want;
    s = '{st(0, 1, 3, 32'h11, 1, 6, 32'h66, 1, 5, 5, 6),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
          st(1, 1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(1, 1, 0, 1, 0, 0, 0, 3, 32'h11)};
    for (int i = 0; i < 3; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_contention();
    stim_t s[4];
    obs_t  e[4];
    obs_t  got, want;
    s = '{st(1, 1, 4, 32'hA, 1, 5, 32'hB, 0, 0, 0, 0),
          st(1, 1, 4, 32'hA, 1, 5, 32'hB, 0, 0, 0, 0),
          st(1, 1, 4, 32'hA, 1, 5, 32'hB, 0, 0, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    e = '{mk(1, 1, 0, 1, 0, 0, 0, 4, 32'hA),
          mk(1, 0, 1, 1, 0, 0, 0, 5, 32'hB),
          mk(1, 1, 0, 1, 0, 0, 0, 4, 32'hA),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL contention[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_scoreboard();
    stim_t s[5];
    obs_t  e[5];
    obs_t  got, want;
    s = '{st(1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0),
          st(1, 1, 8, 32'h55, 0, 0, 0, 0, 8, 8, 0),
          st(1, 1, 8, 32'h55, 1, 8, 32'hCAFE, 0, 0, 8, 0),
          st(1, 1, 8, 32'h55, 0, 0, 0, 0, 0, 8, 0)};
    e = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(0, 0, 0, 1, 1, 0, 1, 0, 0),
          mk(0, 0, 0, 0, 1, 0, 1, 0, 0),
          mk(1, 0, 1, 1, 1, 0, 1, 8, 32'hCAFE),
          mk(1, 1, 0, 1, 0, 0, 0, 8, 32'h55)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scoreboard[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t s[5];
    obs_t  e[5];
    obs_t  got, want;
    s = '{st(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0),
          st(1, 0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0),
          st(1, 0, 0, 0, 1, 9, 32'h1, 0, 0, 9, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0)};
    e = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(1, 0, 1, 1, 1, 0, 1, 9, 32'h99),
          mk(0, 0, 0, 1, 1, 0, 1, 0, 0),
          mk(1, 0, 1, 1, 1, 0, 1, 9, 32'h1),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL same_cycle[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_reg0();
    stim_t s[6];
    obs_t  e[6];
    obs_t  got, want;
    s = '{st(1, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),
          st(1, 0, 0, 0, 1, 0, 32'h5, 0, 0, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
          st(1, 0, 0, 0, 1, 12, 32'h12, 0, 0, 12, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 0)};
    e = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 0),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(0, 0, 1, 1, 0, 0, 0, 0, 0),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(1, 0, 1, 1, 0, 0, 0, 12, 32'h12),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 6; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reg0[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[7];
    obs_t  e[7];
    obs_t  got, want;
    s = '{st(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0),
          st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7),
          st(0, 1, 4, 32'hA, 1, 5, 32'hB, 1, 3, 1, 2),
          st(1, 1, 4, 32'hA, 1, 5, 32'hB, 0, 0, 1, 2),
          st(1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 7)};
    e = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 0),
          mk(0, 0, 0, 1, 0, 0, 1, 0, 0),
          mk(0, 0, 0, 1, 0, 0, 2, 0, 0),
          mk(0, 0, 0, 1, 1, 1, 3, 0, 0),
          mk(0, 0, 0, 0, 0, 0, 3, 0, 0),
          mk(1, 1, 0, 1, 0, 0, 0, 4, 32'hA),
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      apply(s[i], e[i]);
      @(negedge clk);
      got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_reg0();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources.
  - Channel A: the single-cycle core writeback.
  - Channel B: a long-latency functional unit (mult/div, memory refill).
- Keeps a per-register scoreboard of outstanding long-latency destinations. Uses it to flag read hazards and block out-of-order (WAW) writes.
- Sits between the execute/writeback stages and the register file write inputs (reg_write, write_reg, write_data).

Parameters:
- DW, 32, data width of register file words
- AW, 5, register address width
- NREG, 32, number of architectural registers (2**AW)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_valid  in  1  channel A write request
- a_addr  in  AW  channel A destination register
- a_data  in  DW  channel A write data
- a_ready  out  1  channel A write accepted this cycle
- b_valid  in  1  channel B write request (completion of a long op)
- b_addr  in  AW  channel B destination register
- b_data  in  DW  channel B write data
- b_ready  out  1  channel B write accepted this cycle
- iss_valid  in  1  long op issued; reserve destination
- iss_addr  in  AW  destination reserved by the long op
- iss_ready  out  1  reservation accepted
- rd_addr1  in  AW  read port 1 address (from decode)
- rd_addr2  in  AW  read port 2 address
- hazard1  out  1  rd_addr1 has an outstanding long-op write
- hazard2  out  1  rd_addr2 has an outstanding long-op write
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- busy_cnt  out  AW+1  number of reserved registers

Behaviour:
- State:
  - busy[NREG-1:0] scoreboard
  - rr_last: 1 bit, last channel granted under contention
  - busy_cnt register
- Reset (rst_n=0 at posedge):
  - busy=0, rr_last=B (so A wins the first conflict), busy_cnt=0.
  - All outputs combinational from state and inputs. During reset cycles, rf_we, a_ready, b_ready and iss_ready are forced 0, and hazard1/2 read 0.
- Eligibility:
  - A is eligible when a_valid && !busy[a_addr]. A write to a pending register stalls until B retires it (WAW order).
  - B is eligible when b_valid.
- Grant:
  - Only one eligible channel: it is granted.
  - Both eligible: the channel that is not rr_last is granted, then rr_last is updated to the winner. rr_last changes only on contention.
- Write port, zero latency:
  - rf_we=1 whenever a grant exists; the register file commits at the same posedge.
  - rf_waddr/rf_wdata are the winner's fields; when rf_we=0 they are 0.
  - a_ready / b_ready equal their respective grants.
- Register 0:
  - A granted write with a_addr=0 still handshakes (ready=1) but drives rf_we=0. The same rule applies to B.
  - iss_addr=0: iss_ready=1 and no busy bit is set.
  - hazard on address 0 is always 0.
- Scoreboard:
  - On a granted B write, busy[b_addr] is cleared at the posedge.
  - On iss_valid && iss_ready, busy[iss_addr] is set at the posedge.
  - iss_ready = !busy[iss_addr] || (B granted && b_addr==iss_addr).
  - Set and clear of the same register in one cycle: final busy=1.
- Hazards:
  - hazardN = busy[rd_addrN], using the registered value.
  - A hazard drops the cycle after the B write commits, when the register file holds the new data.
- busy_cnt:
  - +1 on an effective set, -1 on an effective clear, unchanged when both hit the same register or both are absent.
  - Range 0..NREG-1.
- B write to a non-busy register is legal: it is written, and busy is unchanged.
- Reset mid-operation discards all reservations and pending contention. Requesters re-present their requests after reset.

Test Plan:
- Reset, then idle: rf_we=0, hazard1/2=0, busy_cnt=0. Then a_valid, a_addr=3, a_data=0x11 → rf_we=1, rf_waddr=3, rf_wdata=0x11, a_ready=1.
- Contention, both valid for 3 cycles (A addr 4 data 0xA, B addr 5 data 0xB) → grants A, B, A, with the loser's ready=0 each cycle.
- iss addr 8, next cycle rd_addr1=8 → hazard1=1 and busy_cnt=1. A write to 8 → a_ready=0 (stalled). B write to 8 data 0xCAFE → rf_we=1, busy_cnt=0, hazard1=0 next cycle, then A to 8 is accepted.
- Same-cycle B write to 9 and iss addr 9 while busy[9]=1 → iss_ready=1, busy[9] stays 1, busy_cnt unchanged.
- Register 0: A write addr 0 → a_ready=1, rf_we=0. iss addr 0 → busy_cnt stays 0, hazard on rd_addr 0 stays 0.
- Reserve registers 1, 2, 7, then assert rst_n=0 for one cycle → busy_cnt=0 and all hazards 0 after reset.
